// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock-enable generator.
// Provides the channel-index width helper and the "channel off" divisor.
package clk_div_pkg;

    // Divisor value that switches a channel off.
    localparam int DIV_OFF = 0;

    // Width of a channel index: at least one bit even for a single channel.
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, tick and square out.
// Ports: clk12m, reset_n, en, sync_clr, wr/wval (write), tick, sq, pend.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int CNT_W  = 24
) (
    input  logic             clk12m,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             wr,
    input  logic [CNT_W-1:0] wval,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t RST_DIV = cnt_t'(CLK_HZ);
    localparam cnt_t OFF     = cnt_t'(DIV_OFF);

    cnt_t cnt, div, pdiv;
    cnt_t cnt_d, div_d, pdiv_d;
    cnt_t nxt, pv, ld;
    logic tick_d, sq_d, pend_d;
    logic wrap, pp, off;

    always_comb begin
        cnt_d  = cnt;
        div_d  = div;
        pdiv_d = pdiv;
        pend_d = pend;
        tick_d = 1'b0;
        sq_d   = sq;

        off  = (div == OFF);
        nxt  = cnt + 1'b1;
        wrap = !off && (cnt == div - 1'b1);

        // A write this cycle behaves as if it were already pending,
        // so a write coinciding with a wrap or sync_clr is applied there.
        pv = pdiv;
        pp = pend;
        if (wr) begin
            pv = wval;
            pp = 1'b1;
        end
        ld = pp ? pv : div;

        if (wr && wval == OFF) begin
            div_d  = OFF;
            cnt_d  = '0;
            sq_d   = 1'b0;
            pdiv_d = '0;
            pend_d = 1'b0;
        end else if (wr && off) begin
            // Off channel: nothing to finish, start the new period now.
            div_d  = wval;
            cnt_d  = '0;
            sq_d   = ((wval >> 1) == '0);
            pdiv_d = '0;
            pend_d = 1'b0;
        end else if (sync_clr) begin
            cnt_d  = '0;
            div_d  = ld;
            pdiv_d = '0;
            pend_d = 1'b0;
            sq_d   = (ld != OFF) && ((ld >> 1) == '0);
        end else if (en && !off) begin
            if (wrap) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                div_d  = ld;
                pdiv_d = '0;
                pend_d = 1'b0;
                sq_d   = ((ld >> 1) == '0);
            end else begin
                cnt_d  = nxt;
                pdiv_d = pv;
                pend_d = pp;
                sq_d   = (nxt >= (div >> 1));
            end
        end else begin
            pdiv_d = pv;
            pend_d = pp;
        end
    end

    always_ff @(posedge clk12m or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            div  <= RST_DIV;
            pdiv <= '0;
            pend <= 1'b0;
            tick <= 1'b0;
            sq   <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            div  <= div_d;
            pdiv <= pdiv_d;
            pend <= pend_d;
            tick <= tick_d;
            sq   <= sq_d;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable generator (tick + square per ch).
// Ports: clk12m, reset_n, en, sync_clr, div_wr/div_ch/div_val, tick, sq, pend.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int CLK_HZ = 12_000_000,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 24
) (
    input  logic                      clk12m,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      sync_clr,
    input  logic                      div_wr,
    input  logic [ch_w(NUM_CH)-1:0]   div_ch,
    input  logic [CNT_W-1:0]          div_val,
    output logic [NUM_CH-1:0]         tick,
    output logic [NUM_CH-1:0]         sq,
    output logic [NUM_CH-1:0]         pend
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;

        // Indices >= NUM_CH match no channel, so such writes are dropped.
        assign wr = div_wr && (int'(div_ch) == i);

        clk_div_chan #(
            .CLK_HZ (CLK_HZ),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk12m   (clk12m),
            .reset_n  (reset_n),
            .en       (en),
            .sync_clr (sync_clr),
            .wr       (wr),
            .wval     (div_val),
            .tick     (tick[i]),
            .sq       (sq[i]),
            .pend     (pend[i])
        );
    end

endmodule
